// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed byte/half/word requests into word
// accesses on a 32-bit word-addressed data memory. Sub-word stores are
// read-modify-write, loads are sign/zero-extended, bad alignment is rejected.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misaligned_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read_signal,
  output logic        mem_write_signal,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        error_q, error_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        accept;

  // Alignment rule: halves need an even address, words a multiple of four,
  // and size 11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed little-endian lane(s) out of a memory word and extend.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old memory word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (size == SIZE_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  assign accept = req_valid && req_ready_q;

  // Next-state logic plus next values of every latched field and of the
  // registered Moore outputs, which are decoded from the upcoming state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE, S_RESP, S_ERR: begin
        state_d = S_IDLE;
        if (accept) begin
          addr_d     = req_address;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata[15:0];
          if (is_misaligned(req_size, req_address[1:0])) begin
            state_d = S_ERR;
          end else if (!req_write) begin
            state_d = S_RD;
          end else if (req_size == SIZE_WORD) begin
            state_d   = S_WR;
            wr_data_d = req_wdata;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = extract_load(mem_read_data, addr_q[1:0], size_q, unsigned_q);
        state_d = S_RESP;
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        wr_data_d = merge_store(mem_read_data, addr_q[1:0], size_q, wdata_q);
        state_d   = S_RMW_WR;
      end
      S_RMW_WR: begin
        state_d = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d  = (state_d == S_IDLE) || (state_d == S_RESP) || (state_d == S_ERR);
    resp_valid_d = (state_d == S_RESP) || (state_d == S_ERR);
    error_d      = (state_d == S_ERR);
    mem_rd_d     = (state_d == S_RD) || (state_d == S_RMW_RD);
    mem_wr_d     = (state_d == S_WR) || (state_d == S_RMW_WR);
  end

  // State, latched request fields and registered outputs; reset clears all
  // enables at once so an in-flight write never sees a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 16'h0;
      rdata_q      <= 32'h0;
      wr_data_q    <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      error_q      <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      wr_data_q    <= wr_data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      error_q      <= error_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign misaligned_error = error_q;
  assign resp_rdata       = rdata_q;
  assign mem_address      = {2'b00, addr_q[31:2]};
  assign mem_write_data   = wr_data_q;
  assign mem_read_signal  = mem_rd_q;
  assign mem_write_signal = mem_wr_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath (ALU address, register-file store data) and the 32-bit word-addressed data memory unit, and drives that memory's address, write-data, read and write signals.
- Converts byte-addressed load/store requests of byte, halfword and word size into word accesses.
- Sub-word stores are done as read-modify-write.
- Loads are sign- or zero-extended. Misaligned and illegal-size requests are flagged.

Parameters:
- none; data and address width fixed at 32.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and accepting
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
- req_address  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load result
- misaligned_error  output  1  qualifies resp_valid; request rejected
- mem_address  output  32  word index to data memory = latched address >> 2
- mem_write_data  output  32  word to be written
- mem_read_signal  output  1  memory read enable
- mem_write_signal  output  1  memory write enable; memory writes on rising clk edge
- mem_read_data  input  32  memory read data, combinational from mem_address

Behaviour:
- Handshake: a transfer occurs on a rising edge with req_valid && req_ready. At that edge the unit latches address, size, write, unsigned and wdata. Requests while busy are ignored; the requester holds them.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by address[1:0]. A halfword at offset 0 uses [15:0]; at offset 2 it uses [31:16].
- A request is misaligned if it is a halfword with address[0]=1, a word with address[1:0]!=0, or req_size=11.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP, ERR.
  - IDLE: req_ready=1. All mem_* enables are 0.
    - Accepted misaligned or illegal request -> ERR.
    - Load -> RD.
    - Word store -> WR.
    - Byte or half store -> RMW_RD.
  - RD: mem_read_signal=1. At the edge, resp_rdata is loaded with the selected lane(s), extended per the latched unsigned bit (word: passthrough). -> RESP.
  - WR: mem_write_signal=1, mem_write_data = latched wdata. -> RESP.
  - RMW_RD: mem_read_signal=1. At the edge, the merge register is loaded with mem_read_data, with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. -> RMW_WR.
  - RMW_WR: mem_write_signal=1, mem_write_data = merge register. -> RESP.
  - RESP: resp_valid=1, misaligned_error=0. -> IDLE.
  - ERR: resp_valid=1, misaligned_error=1. No memory enable asserts in any cycle of the request. -> IDLE.
- Memory-side outputs are Moore outputs, decoded from state and latched registers. read and write are never both 1.
- Latency from the acceptance edge to the resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back throughput: the next request can be accepted on the edge that leaves RESP or ERR, since IDLE is entered then.
- resp_rdata holds its value until the next load completes. Stores and errors leave it unchanged.
- Reset (asynchronous, any state):
  - Immediately forces IDLE.
  - resp_valid, misaligned_error, mem_read_signal and mem_write_signal go to 0.
  - resp_rdata, mem_address, mem_write_data and the internal latches go to 0.
  - req_ready=1 while in IDLE after reset.
  - A write in progress is aborted; no memory edge occurs with write enabled during reset.
- Address bits [1:0] never reach mem_address. Word index wraps naturally (address 0xFFFFFFFC -> index 0x3FFFFFFF).

Test Plan:
- Preload word index 1 = 0x8899AABB. Load word at 0x4 -> resp_valid 2 cycles after acceptance, resp_rdata=0x8899AABB, mem_address=1 with mem_read_signal during RD.
- Signed byte load at 0x5 -> resp_rdata=0xFFFFFFAA. Unsigned byte load at 0x5 -> 0x000000AA. Unsigned half load at 0x6 -> 0x00008899.
- Halfword store at 0x6 with wdata 0x00001234 -> one read cycle, then write of 0x1234AABB to index 1, resp_valid 3 cycles after acceptance. A later word load at 0x4 returns 0x1234AABB.
- Halfword load at 0x3, word store at 0x2, and size=11 at 0x0 -> each gives resp_valid with misaligned_error=1 one cycle after acceptance. No read/write enable ever asserts; memory is unchanged.
- Byte store 0xEE at 0x4 with reset asserted mid-RMW_WR -> mem_write_signal drops the same instant, index 1 keeps its prior value, all outputs 0, req_ready=1 after release.
- req_valid held high across a word store to 0x8 then a word load from 0x8 -> second request accepted on the edge leaving RESP; load returns the stored value; no idle cycle between them.
